// File: rtl/spi_slave_responder.sv
// SPI mode-0 slave that receives 48-bit SD-style command frames and answers with a response
// byte after NCR filler bytes. The master bus is oversampled on clk through synchroniser flops.
module spi_slave_responder #(
  parameter int unsigned CMD_WIDTH   = 48,
  parameter int unsigned NCR_BYTES   = 1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2:0]           to_slave_i,
  output logic                 from_slave_o,
  output logic [CMD_WIDTH-1:0] cmd_o,
  output logic                 cmd_valid_o,
  input  logic                 cmd_ready_i,
  input  logic [7:0]           resp_i,
  input  logic                 resp_valid_i,
  output logic                 resp_ready_o,
  output logic                 frame_err_o,
  output logic                 overrun_o
);

  localparam int unsigned CntW = $clog2(CMD_WIDTH + 1);
  localparam int unsigned NcrW = $clog2(NCR_BYTES + 1);
  localparam logic [CntW-1:0] LastBit = CntW'(CMD_WIDTH - 1);
  localparam logic [NcrW-1:0] NcrLast = NcrW'(NCR_BYTES);

  typedef enum logic [1:0] {StHunt, StRxCmd, StWaitNcr, StTxResp} state_e;
  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0][2:0] sync_q;
  logic                        sclk_prev_q;
  logic                        cs_n, sclk, mosi, rise, fall;

  logic [CMD_WIDTH-1:0] rx_sh_q, cmd_q;
  logic [CntW-1:0]      rx_cnt_q;
  logic [2:0]           bit_idx_q;
  logic [NcrW-1:0]      ncr_cnt_q;
  logic [7:0]           tx_sh_q;
  logic                 miso_q, cmd_valid_q, frame_err_q, overrun_q;

  logic [CMD_WIDTH-1:0] rx_next;
  logic                 frame_done, frame_ok, byte_load, ncr_done, load_resp;
  logic [7:0]           tx_byte;

  assign {cs_n, sclk, mosi} = sync_q[SYNC_STAGES-1];
  // Strobes are suppressed while cs_n is high, so a coincident cs_n rise always wins.
  assign rise = ~cs_n & sclk & ~sclk_prev_q;
  assign fall = ~cs_n & ~sclk & sclk_prev_q;

  assign rx_next    = {rx_sh_q[CMD_WIDTH-2:0], mosi};
  assign frame_done = rise && (state_q == StRxCmd) && (rx_cnt_q == LastBit);
  assign frame_ok   = rx_next[CMD_WIDTH-2] & rx_next[0];
  assign byte_load  = fall && (state_q == StWaitNcr) && (bit_idx_q == 3'd0);
  assign ncr_done   = (ncr_cnt_q == NcrLast);
  assign load_resp  = byte_load & ncr_done & resp_valid_i;
  assign tx_byte    = load_resp ? resp_i : 8'hFF;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q      <= {SYNC_STAGES{3'b100}};
      sclk_prev_q <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], to_slave_i};
      sclk_prev_q <= sclk;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= StHunt;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (cs_n) begin
      state_d = StHunt;
    end else begin
      case (state_q)
        StHunt:    if (rise && !mosi) state_d = StRxCmd;
        StRxCmd:   if (frame_done) state_d = frame_ok ? StWaitNcr : StHunt;
        StWaitNcr: if (load_resp) state_d = StTxResp;
        StTxResp:  if (rise && bit_idx_q == 3'd7) state_d = StHunt;
        default:   state_d = StHunt;
      endcase
    end
  end

  always_comb begin
    resp_ready_o = load_resp;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_sh_q     <= '0;
      cmd_q       <= '0;
      rx_cnt_q    <= '0;
      bit_idx_q   <= '0;
      ncr_cnt_q   <= '0;
      tx_sh_q     <= 8'hFF;
      miso_q      <= 1'b1;
      cmd_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      if (cmd_valid_q && cmd_ready_i) cmd_valid_q <= 1'b0;
      if (cs_n) begin
        rx_cnt_q  <= '0;
        bit_idx_q <= '0;
        ncr_cnt_q <= '0;
        tx_sh_q   <= 8'hFF;
        miso_q    <= 1'b1;
      end else begin
        if (rise) begin
          case (state_q)
            StHunt: begin
              if (!mosi) begin
                rx_sh_q  <= rx_next;
                rx_cnt_q <= CntW'(1);
              end
            end
            StRxCmd: begin
              rx_sh_q  <= rx_next;
              rx_cnt_q <= rx_cnt_q + CntW'(1);
              if (frame_done) begin
                bit_idx_q <= '0;
                ncr_cnt_q <= '0;
                if (!frame_ok) begin
                  frame_err_q <= 1'b1;
                end else if (cmd_valid_q) begin
                  overrun_q <= 1'b1;
                end else begin
                  cmd_q       <= rx_next;
                  cmd_valid_q <= 1'b1;
                end
              end
            end
            default: bit_idx_q <= bit_idx_q + 3'd1;
          endcase
        end
        if (fall) begin
          // The load fall drives the new byte's MSB immediately.
          if (byte_load) begin
            miso_q  <= tx_byte[7];
            tx_sh_q <= {tx_byte[6:0], 1'b1};
            if (!ncr_done) ncr_cnt_q <= ncr_cnt_q + NcrW'(1);
          end else begin
            miso_q  <= tx_sh_q[7];
            tx_sh_q <= {tx_sh_q[6:0], 1'b1};
          end
        end
      end
    end
  end

  assign from_slave_o = miso_q;
  assign cmd_o        = cmd_q;
  assign cmd_valid_o  = cmd_valid_q;
  assign frame_err_o  = frame_err_q;
  assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_spi_slave_responder.sv
// Bench for spi_slave_responder: drives SPI mode-0 frames at clk/8 and scoreboards received
// commands and MISO response bytes against queues filled as stimulus is issued.
module tb_spi_slave_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs_n, sclk, mosi;
  logic        from_slave;
  logic [47:0] cmd;
  logic        cmd_valid, cmd_ready;
  logic [7:0]  resp;
  logic        resp_valid, resp_ready;
  logic        frame_err, overrun;

  int n_checks = 0;
  int n_errors = 0;
  int n_ferr = 0;
  int n_ovr = 0;
  int n_rr = 0;

  logic [47:0] exp_cmd[$];
  logic [7:0]  exp_miso[$];

  always #5 clk = ~clk;

  spi_slave_responder #(
    .CMD_WIDTH  (48),
    .NCR_BYTES  (1),
    .SYNC_STAGES(2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .to_slave_i  ({cs_n, sclk, mosi}),
    .from_slave_o(from_slave),
    .cmd_o       (cmd),
    .cmd_valid_o (cmd_valid),
    .cmd_ready_i (cmd_ready),
    .resp_i      (resp),
    .resp_valid_i(resp_valid),
    .resp_ready_o(resp_ready),
    .frame_err_o (frame_err),
    .overrun_o   (overrun)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Pulse counting and command scoreboard, sampled away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_err)  n_ferr++;
      if (overrun)    n_ovr++;
      if (resp_ready) n_rr++;
      if (cmd_valid && cmd_ready) begin
        check_eq("cmd", cmd, (exp_cmd.size() > 0) ? {16'h0, exp_cmd.pop_front()} : 64'hDEAD);
      end
    end
  end

  task automatic spi_bit(input logic b, output logic r);
    sclk = 1'b0;
    mosi = b;
    repeat (4) @(negedge clk);
    r    = from_slave;
    sclk = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic run_frame(input logic [47:0] f, input int nbits, input int post_bytes,
                           input int raise_at);
    logic        r;
    logic [7:0]  got;
    logic [47:0] sh;
    sh   = f;
    got  = 8'h00;
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      spi_bit(sh[47], r);
      sh = sh << 1;
    end
    for (int k = 0; k < post_bytes; k++) begin
      for (int j = 0; j < 8; j++) begin
        if (k * 8 + j == raise_at) resp_valid = 1'b1;
        spi_bit(1'b1, r);
        got = {got[6:0], r};
      end
      check_eq("miso_byte", {56'h0, got},
               (exp_miso.size() > 0) ? {56'h0, exp_miso.pop_front()} : 64'hDEAD);
    end
    sclk = 1'b0;
    repeat (4) @(negedge clk);
    cs_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    logic        r;
    logic [47:0] sh;
    rst        = 1'b1;
    cs_n       = 1'b1;
    sclk       = 1'b0;
    mosi       = 1'b1;
    cmd_ready  = 1'b1;
    resp       = 8'h00;
    resp_valid = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("rst_miso", {63'h0, from_slave}, 64'h1);
    check_eq("rst_cmd", {16'h0, cmd}, 64'h0);
    check_eq("rst_cmd_valid", {63'h0, cmd_valid}, 64'h0);
    check_eq("rst_resp_ready", {63'h0, resp_ready}, 64'h0);
    check_eq("rst_frame_err", {63'h0, frame_err}, 64'h0);
    check_eq("rst_overrun", {63'h0, overrun}, 64'h0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // CMD0 with response already valid: NCR filler then response.
    resp       = 8'h01;
    resp_valid = 1'b1;
    exp_cmd.push_back(48'h400000000095);
    exp_miso.push_back(8'hFF); exp_miso.push_back(8'h01); exp_miso.push_back(8'hFF);
    run_frame(48'h400000000095, 48, 3, -1);
    resp_valid = 1'b0;
    check_eq("rr_after_cmd0", n_rr, 1);

    // Response arrives 20 sclk after the frame: retried at byte boundaries.
    resp = 8'hA5;
    exp_cmd.push_back(48'h510000000055);
    exp_miso.push_back(8'hFF); exp_miso.push_back(8'hFF); exp_miso.push_back(8'hFF);
    exp_miso.push_back(8'hA5); exp_miso.push_back(8'hFF);
    run_frame(48'h510000000055, 48, 5, 20);
    resp_valid = 1'b0;
    check_eq("rr_late", n_rr, 2);

    // Transmit bit clear: format error, nothing reported, no response.
    exp_miso.push_back(8'hFF);
    run_frame(48'h000000000095, 48, 1, -1);
    check_eq("ferr_count", n_ferr, 1);
    check_eq("ferr_cmd_valid", {63'h0, cmd_valid}, 64'h0);

    // Consumer stalled: first frame held, second dropped with overrun.
    cmd_ready  = 1'b0;
    resp       = 8'h3C;
    resp_valid = 1'b1;
    exp_cmd.push_back(48'h4C1234567801);
    exp_miso.push_back(8'hFF); exp_miso.push_back(8'h3C); exp_miso.push_back(8'hFF);
    run_frame(48'h4C1234567801, 48, 3, -1);
    exp_miso.push_back(8'hFF); exp_miso.push_back(8'h3C); exp_miso.push_back(8'hFF);
    run_frame(48'h4DDEADBEEFFF, 48, 3, -1);
    resp_valid = 1'b0;
    check_eq("ovr_count", n_ovr, 1);
    check_eq("ovr_held_valid", {63'h0, cmd_valid}, 64'h1);
    check_eq("ovr_held_cmd", {16'h0, cmd}, 64'h4C1234567801);
    check_eq("rr_overrun", n_rr, 4);
    cmd_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("ovr_released", {63'h0, cmd_valid}, 64'h0);

    // Frame aborted by cs_n after 20 bits, then a full CMD8.
    run_frame(48'h48000001AA87, 20, 0, -1);
    exp_cmd.push_back(48'h48000001AA87);
    exp_miso.push_back(8'hFF);
    run_frame(48'h48000001AA87, 48, 1, -1);
    check_eq("abort_cmd_o", {16'h0, cmd}, 64'h48000001AA87);

    // Reset in the middle of a frame.
    sh   = 48'h7700000000FF;
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 30; i++) begin
      spi_bit(sh[47], r);
      sh = sh << 1;
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("midrst_cmd", {16'h0, cmd}, 64'h0);
    check_eq("midrst_cmd_valid", {63'h0, cmd_valid}, 64'h0);
    check_eq("midrst_miso", {63'h0, from_slave}, 64'h1);
    sclk = 1'b0;
    cs_n = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    resp       = 8'h01;
    resp_valid = 1'b1;
    exp_cmd.push_back(48'h400000000095);
    exp_miso.push_back(8'hFF); exp_miso.push_back(8'h01); exp_miso.push_back(8'hFF);
    run_frame(48'h400000000095, 48, 3, -1);
    resp_valid = 1'b0;
    repeat (4) @(negedge clk);

    check_eq("final_rr", n_rr, 5);
    check_eq("final_ferr", n_ferr, 1);
    check_eq("final_ovr", n_ovr, 1);
    check_eq("cmd_q_left", exp_cmd.size(), 0);
    check_eq("miso_q_left", exp_miso.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
